// File: rtl/matrix_loader_pkg.sv
// Shared widths and loader FSM state type for the matrix operand path.
// The multiply datapath imports the same default widths.
package matrix_loader_pkg;

  localparam int unsigned LOADER_DATA_WIDTH      = 8;
  localparam int unsigned LOADER_ADDR_WIDTH      = 13;
  localparam int unsigned LOADER_NUM_ELEMS       = 256;
  localparam int unsigned LOADER_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    LOAD,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw active-low button, debounces it and emits a one-cycle pulse per press.
// Releases produce no pulse.
module button_debouncer
  import matrix_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = LOADER_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_l,
  input  logic raw_l,
  output logic press_pulse
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync_q1;
  logic                 sync_q2;
  logic                 stable;
  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sync_q1     <= 1'b1;
      sync_q2     <= 1'b1;
      stable      <= 1'b1;
      count       <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_q1     <= raw_l;
      sync_q2     <= sync_q1;
      press_pulse <= 1'b0;
      if (sync_q2 == stable) begin
        count <= '0;
      end else if (count == CNT_MAX) begin
        stable      <= sync_q2;
        count       <= '0;
        // Only a released->pressed change (stable was 1) yields a pulse.
        press_pulse <= stable;
      end else begin
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Writes one operator-keyed element per debounced button press into the operand RAM,
// at consecutive addresses, and flags load_done once the matrix is full.
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = LOADER_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = LOADER_ADDR_WIDTH,
  parameter int unsigned NUM_ELEMS       = LOADER_NUM_ELEMS,
  parameter int unsigned DEBOUNCE_CYCLES = LOADER_DEBOUNCE_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset_l,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  press_l,
  input  logic                  restart,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH:0]   elem_count,
  output logic                  load_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_ELEMS - 1);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(NUM_ELEMS);

  loader_state_t state;
  logic          press_pulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock      (clock),
    .reset_l    (reset_l),
    .raw_l      (press_l),
    .press_pulse(press_pulse)
  );

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state      <= LOAD;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      elem_count <= '0;
      load_done  <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      // A restart in WRITE still lets the already-raised ram_we finish this cycle.
      if (restart) begin
        state      <= LOAD;
        ram_addr   <= '0;
        elem_count <= '0;
        load_done  <= 1'b0;
      end else begin
        unique case (state)
          LOAD: begin
            if (press_pulse) begin
              ram_data <= data_in;
              ram_we   <= 1'b1;
              state    <= WRITE;
            end
          end
          WRITE: begin
            if (elem_count != FULL_COUNT) begin
              elem_count <= elem_count + (ADDR_WIDTH + 1)'(1);
            end
            if (ram_addr == LAST_ADDR) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              ram_addr <= ram_addr + ADDR_WIDTH'(1);
              state    <= LOAD;
            end
          end
          DONE: begin
            load_done <= 1'b1;
          end
          default: begin
            state <= LOAD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader with a short debounce window and a four-element matrix.
module tb_matrix_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 13;
  localparam int unsigned NE = 4;
  localparam int unsigned DC = 4;

  logic          clock = 1'b0;
  logic          reset_l;
  logic [DW-1:0] data_in;
  logic          press_l;
  logic          restart;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [AW:0]   elem_count;
  logic          load_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic [AW:0]   wr_cnt[$];

  matrix_loader #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .NUM_ELEMS      (NE),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock     (clock),
    .reset_l   (reset_l),
    .data_in   (data_in),
    .press_l   (press_l),
    .restart   (restart),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .elem_count(elem_count),
    .load_done (load_done)
  );

  always #5 clock = ~clock;

  // Record every RAM write seen mid-cycle.
  always @(negedge clock) begin
    if (ram_we) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_data);
      wr_cnt.push_back(elem_count);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cnt.delete();
  endtask

  task automatic press(input logic [DW-1:0] d, input int hold);
    data_in = d;
    press_l = 1'b0;
    idle(hold);
    press_l = 1'b1;
    idle(10);
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    idle(1);
    restart = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    press_l = 1'b1;
    restart = 1'b0;
    data_in = '0;
    idle(2);
    n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL rst_addr_in_reset: got %0h want 0", ram_addr); end
    reset_l = 1'b1;
    idle(20);
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", ram_we); end
    n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL rst_addr: got %0h want 0", ram_addr); end
    n_cmp++; if (ram_data !== '0) begin n_bad++; $display("FAIL rst_data: got %0h want 0", ram_data); end
    n_cmp++; if (elem_count !== '0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", elem_count); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", load_done); end
    n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL rst_no_write: got %0d writes want 0", wr_addr.size()); end
  endtask

  task automatic test_debounce();
    clear_log();
    data_in = 8'h5A;
    press_l = 1'b0;
    idle(3);
    press_l = 1'b1;
    idle(10);
    n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL bounce_no_write: got %0d writes want 0", wr_addr.size()); end
    press(8'h5A, 10);
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL press_one_write: got %0d writes want 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      n_cmp++; if (wr_addr[0] !== 13'd0) begin n_bad++; $display("FAIL press_addr: got %0h want 0", wr_addr[0]); end
      n_cmp++; if (wr_data[0] !== 8'h5A) begin n_bad++; $display("FAIL press_data: got %0h want 5a", wr_data[0]); end
      n_cmp++; if (wr_cnt[0] !== 14'd0) begin n_bad++; $display("FAIL press_count_lag: got %0d want 0", wr_cnt[0]); end
    end
    n_cmp++; if (elem_count !== 14'd1) begin n_bad++; $display("FAIL press_count: got %0d want 1", elem_count); end
    n_cmp++; if (ram_addr !== 13'd1) begin n_bad++; $display("FAIL press_next_addr: got %0h want 1", ram_addr); end
    n_cmp++; if (ram_data !== 8'h5A) begin n_bad++; $display("FAIL press_data_hold: got %0h want 5a", ram_data); end
  endtask

  task automatic test_full_load();
    logic [DW-1:0] vals[4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    restart_pulse();
    n_cmp++; if (elem_count !== '0) begin n_bad++; $display("FAIL full_restart_count: got %0d want 0", elem_count); end
    clear_log();
    for (int i = 0; i < 4; i++) begin
      press(vals[i], 10);
    end
    n_cmp++; if (wr_addr.size() != 4) begin n_bad++; $display("FAIL full_writes: got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      n_cmp++; if (wr_addr[i] !== AW'(i)) begin n_bad++; $display("FAIL full_addr%0d: got %0h want %0h", i, wr_addr[i], i); end
      n_cmp++; if (wr_data[i] !== vals[i]) begin n_bad++; $display("FAIL full_data%0d: got %0h want %0h", i, wr_data[i], vals[i]); end
    end
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %b want 1", load_done); end
    n_cmp++; if (elem_count !== 14'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", elem_count); end
    press(8'h55, 10);
    n_cmp++; if (wr_addr.size() != 4) begin n_bad++; $display("FAIL done_ignore: got %0d writes want 4", wr_addr.size()); end
    n_cmp++; if (ram_addr !== 13'd3) begin n_bad++; $display("FAIL done_addr: got %0h want 3", ram_addr); end
    n_cmp++; if (elem_count !== 14'd4) begin n_bad++; $display("FAIL done_count: got %0d want 4", elem_count); end
    n_cmp++; if (ram_data !== 8'h44) begin n_bad++; $display("FAIL done_data: got %0h want 44", ram_data); end
  endtask

  task automatic test_hold();
    restart_pulse();
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL hold_restart_done: got %b want 0", load_done); end
    clear_log();
    data_in = 8'h66;
    press_l = 1'b0;
    idle(100);
    press_l = 1'b1;
    idle(2);
    press_l = 1'b0;
    idle(10);
    press_l = 1'b1;
    idle(10);
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL hold_single: got %0d writes want 1", wr_addr.size()); end
    n_cmp++; if (elem_count !== 14'd1) begin n_bad++; $display("FAIL hold_count: got %0d want 1", elem_count); end
    n_cmp++; if (ram_addr !== 13'd1) begin n_bad++; $display("FAIL hold_addr: got %0h want 1", ram_addr); end
  endtask

  task automatic test_back_to_back_restart();
    restart_pulse();
    press(8'h01, 10);
    press(8'h02, 10);
    n_cmp++; if (elem_count !== 14'd2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", elem_count); end
    clear_log();
    data_in = 8'h03;
    press_l = 1'b0;
    idle(6);
    // press_pulse is high during this cycle; restart lands on the same edge.
    restart = 1'b1;
    idle(1);
    restart = 1'b0;
    idle(4);
    press_l = 1'b1;
    idle(10);
    n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL coinc_no_write: got %0d writes want 0", wr_addr.size()); end
    n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL coinc_addr: got %0h want 0", ram_addr); end
    n_cmp++; if (elem_count !== '0) begin n_bad++; $display("FAIL coinc_count: got %0d want 0", elem_count); end
    press(8'h04, 10);
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL coinc_next_write: got %0d writes want 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      n_cmp++; if (wr_addr[0] !== 13'd0) begin n_bad++; $display("FAIL coinc_next_addr: got %0h want 0", wr_addr[0]); end
      n_cmp++; if (wr_data[0] !== 8'h04) begin n_bad++; $display("FAIL coinc_next_data: got %0h want 04", wr_data[0]); end
    end
  endtask

  task automatic test_async_reset();
    restart_pulse();
    press(8'h10, 10);
    n_cmp++; if (elem_count !== 14'd1) begin n_bad++; $display("FAIL ar_pre_count: got %0d want 1", elem_count); end
    data_in = 8'h20;
    press_l = 1'b0;
    idle(3);
    #2;
    reset_l = 1'b0;
    #1;
    n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL ar_addr: got %0h want 0", ram_addr); end
    n_cmp++; if (elem_count !== '0) begin n_bad++; $display("FAIL ar_count: got %0d want 0", elem_count); end
    n_cmp++; if (ram_data !== '0) begin n_bad++; $display("FAIL ar_data: got %0h want 0", ram_data); end
    n_cmp++; if (ram_we !== 1'b0 || load_done !== 1'b0) begin n_bad++; $display("FAIL ar_flags: got we=%b done=%b want 0 0", ram_we, load_done); end
    press_l = 1'b1;
    idle(2);
    reset_l = 1'b1;
    idle(5);
    clear_log();
    press(8'h30, 10);
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL ar_next_write: got %0d writes want 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      n_cmp++; if (wr_addr[0] !== 13'd0) begin n_bad++; $display("FAIL ar_next_addr: got %0h want 0", wr_addr[0]); end
      n_cmp++; if (wr_data[0] !== 8'h30) begin n_bad++; $display("FAIL ar_next_data: got %0h want 30", wr_data[0]); end
    end
    n_cmp++; if (elem_count !== 14'd1) begin n_bad++; $display("FAIL ar_next_count: got %0d want 1", elem_count); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_full_load();
    test_hold();
    test_back_to_back_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
